// File: rtl/frame_pkg.sv
// frame_pkg: definitions shared by the serial frame decoder.
//   state_t : decoder FSM state encoding
//   BYTE_W  : width of a decoded byte
//   CNT_W   : width of the bit position counter within a byte
package frame_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    HUNT  = 2'b00,
    DATA  = 2'b01,
    STOP  = 2'b10,
    START = 2'b11
  } state_t;

endpackage

// File: rtl/frame_byte_asm.sv
// frame_byte_asm: assembles committed bits into bytes and hands them to a
// consumer with a valid/ready handshake.
//   CLK, CLR    : clock, asynchronous active-high reset
//   commit      : a bit with a good stop is committed this cycle
//   bit_in      : the bit being committed
//   discard     : frame violation; drop the partial byte
//   dout_ready  : consumer accepts data this cycle
//   data        : holding register with the last loaded byte
//   data_valid  : data holds an unconsumed byte
//   overflow    : sticky; a completed byte was dropped
module frame_byte_asm
  import frame_pkg::*;
(
  input  logic              CLK,
  input  logic              CLR,
  input  logic              commit,
  input  logic              bit_in,
  input  logic              discard,
  input  logic              dout_ready,
  output logic [BYTE_W-1:0] data,
  output logic              data_valid,
  output logic              overflow
);

  logic [BYTE_W-1:0] shift_reg;
  logic [BYTE_W-1:0] byte_full;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [BYTE_W-1:0] data_reg;
  logic              data_valid_reg;
  logic              overflow_reg;

  logic byte_done;
  logic load;
  logic accept;

  // Each bit position is written only when bit_cnt points at it, so the
  // completed byte is the stored bits with the incoming bit merged in.
  genvar gi;
  generate
    for (gi = 0; gi < BYTE_W; gi++) begin : g_bit
      always_ff @(posedge CLK or posedge CLR) begin
        if (CLR)
          shift_reg[gi] <= 1'b0;
        else if (discard)
          shift_reg[gi] <= 1'b0;
        else if (commit && (bit_cnt_reg == CNT_W'(gi)))
          shift_reg[gi] <= bit_in;
      end

      assign byte_full[gi] = (commit && (bit_cnt_reg == CNT_W'(gi))) ? bit_in : shift_reg[gi];
    end
  endgenerate

  assign byte_done = commit && (bit_cnt_reg == CNT_W'(BYTE_W - 1));
  assign accept    = data_valid_reg && dout_ready;
  // A new byte may replace the held one only if the held one leaves this cycle.
  assign load      = byte_done && (!data_valid_reg || dout_ready);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      bit_cnt_reg    <= '0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      if (discard)
        bit_cnt_reg <= '0;
      else if (commit)
        bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);  // wraps to 0 after the last bit

      if (load) begin
        data_reg       <= byte_full;
        data_valid_reg <= 1'b1;
      end else if (accept) begin
        data_valid_reg <= 1'b0;
      end

      if (byte_done && !load)
        overflow_reg <= 1'b1;
    end
  end

  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign overflow   = overflow_reg;

endmodule

// File: rtl/frame_decoder.sv
// frame_decoder: decodes a serial line of 3-cycle frames (start '1', data
// bit, stop '0') into bytes, LSB first.
//   CLK, CLR    : clock, asynchronous active-high reset
//   din         : serial input
//   dout_ready  : consumer accepts data this cycle
//   data        : decoded byte
//   data_valid  : data holds an unconsumed byte
//   sync        : decoder is frame-locked
//   frame_err   : one-cycle pulse after a start or stop violation
//   overflow    : sticky; a completed byte was dropped
//   err_cnt     : saturating frame error count (only with FRAME_ERR_CNT_EN)
// Build option: define FRAME_ERR_CNT_EN to add the err_cnt port and counter.
module frame_decoder
  import frame_pkg::*;
(
  input  logic              CLK,
  input  logic              CLR,
  input  logic              din,
  input  logic              dout_ready,
  output logic [BYTE_W-1:0] data,
  output logic              data_valid,
  output logic              sync,
  output logic              frame_err,
  output logic              overflow
`ifdef FRAME_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  state_t state_reg;
  state_t state_next;

  logic bit_latch_reg;
  logic locked_reg;
  logic frame_err_reg;

  logic capture;
  logic commit;
  logic violation;

  // State register
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)
      state_reg <= HUNT;
    else
      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HUNT:    if (din) state_next = DATA;
      DATA:    state_next = STOP;
      STOP:    state_next = din ? HUNT : START;
      START:   state_next = din ? DATA : HUNT;
      default: state_next = HUNT;
    endcase
  end

  // Output decode
  always_comb begin
    capture   = 1'b0;
    commit    = 1'b0;
    violation = 1'b0;
    case (state_reg)
      DATA:    capture   = 1'b1;
      STOP:    begin
                 commit    = !din;
                 violation = din;
               end
      START:   violation = !din;
      default: ;
    endcase
  end

  // Lock is gained on a good stop and lost on any violation (which is the
  // only way back to HUNT), so sync is low in HUNT by construction.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      bit_latch_reg <= 1'b0;
      locked_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (capture)
        bit_latch_reg <= din;
      if (violation)
        locked_reg <= 1'b0;
      else if (commit)
        locked_reg <= 1'b1;
      frame_err_reg <= violation;
    end
  end

  assign sync      = locked_reg && (state_reg != HUNT);
  assign frame_err = frame_err_reg;

  frame_byte_asm u_byte_asm (
    .CLK        (CLK),
    .CLR        (CLR),
    .commit     (commit),
    .bit_in     (bit_latch_reg),
    .discard    (violation),
    .dout_ready (dout_ready),
    .data       (data),
    .data_valid (data_valid),
    .overflow   (overflow)
  );

`ifdef FRAME_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  // Counts on the same edge frame_err rises, so both agree cycle for cycle.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)
      err_cnt_reg <= 8'h00;
    else if (violation && (err_cnt_reg != 8'hFF))
      err_cnt_reg <= err_cnt_reg + 8'h01;
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_frame_decoder.sv
// tb_frame_decoder: directed self-checking bench for frame_decoder.
module tb_frame_decoder;

  logic       CLK;
  logic       CLR;
  logic       din;
  logic       dout_ready;
  logic [7:0] data;
  logic       data_valid;
  logic       sync;
  logic       frame_err;
  logic       overflow;
`ifdef FRAME_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int err_pulses = 0;
  int p0;

  frame_decoder dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .din        (din),
    .dout_ready (dout_ready),
    .data       (data),
    .data_valid (data_valid),
    .sync       (sync),
    .frame_err  (frame_err),
    .overflow   (overflow)
`ifdef FRAME_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // frame_err is high for whole cycles, so each pulse is seen once here.
  always @(negedge CLK) if (frame_err === 1'b1) err_pulses++;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one line sample; returns 1 time unit after the edge that took it.
  task automatic send_bit(input logic b);
    din = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic b);
    send_bit(1'b1);
    send_bit(b);
    send_bit(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_frame(v[i]);
  endtask

  task automatic do_clr();
    CLR = 1'b1;
    #2;
    CLR = 1'b0;
  endtask

  initial begin
    CLR = 1'b1;
    din = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    // Reset state
    check("rst_data", int'(data), 8'h00);
    check("rst_valid", int'(data_valid), 0);
    check("rst_sync", int'(sync), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovf", int'(overflow), 0);
    CLR = 1'b0;

    // 0xA5 clean, consumer ready
    p0 = err_pulses;
    dout_ready = 1'b1;
    send_bit(1'b1);
    check("a5_sync_before_stop", int'(sync), 0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("a5_sync_locked", int'(sync), 1);
    for (int i = 1; i < 8; i++) send_frame(((8'hA5 >> i) & 8'h01) != 0);
    check("a5_data", int'(data), 8'hA5);
    check("a5_valid", int'(data_valid), 1);
    send_bit(1'b1);
    check("a5_valid_drop", int'(data_valid), 0);
    check("a5_no_ferr", err_pulses - p0, 0);
    $display("scenario 0xA5 clean done");

    // Stop violation in frame 3, then 0x3C
    do_clr();
    p0 = err_pulses;
    send_frame(1'b0);
    send_frame(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("viol_ferr", int'(frame_err), 1);
    check("viol_sync", int'(sync), 0);
    send_bit(1'b1);
    check("viol_ferr_one_cycle", int'(frame_err), 0);
    send_bit(1'b0);
    send_bit(1'b0);
    for (int i = 1; i < 7; i++) send_frame(((8'h3C >> i) & 8'h01) != 0);
    check("viol_no_byte_yet", int'(data_valid), 0);
    send_frame(1'b0);
    check("viol_3c_data", int'(data), 8'h3C);
    check("viol_3c_valid", int'(data_valid), 1);
    check("viol_pulse_count", err_pulses - p0, 1);
    $display("scenario stop violation then 0x3C done");

    // Overflow: 0x11 then 0x22 never consumed
    do_clr();
    dout_ready = 1'b0;
    send_byte(8'h11);
    check("ovf_first_data", int'(data), 8'h11);
    check("ovf_first_valid", int'(data_valid), 1);
    check("ovf_first_flag", int'(overflow), 0);
    send_byte(8'h22);
    check("ovf_data_kept", int'(data), 8'h11);
    check("ovf_valid", int'(data_valid), 1);
    check("ovf_flag", int'(overflow), 1);
    $display("scenario overflow done");

    // 0x22 completes on the edge 0x11 is accepted
    do_clr();
    dout_ready = 1'b0;
    send_byte(8'h11);
    for (int i = 0; i < 7; i++) send_frame(((8'h22 >> i) & 8'h01) != 0);
    send_bit(1'b1);
    send_bit(1'b0);
    dout_ready = 1'b1;
    send_bit(1'b0);
    dout_ready = 1'b0;
    check("same_edge_data", int'(data), 8'h22);
    check("same_edge_valid", int'(data_valid), 1);
    check("same_edge_ovf", int'(overflow), 0);
    $display("scenario same-edge load done");

    // CLR mid-byte, then 0xFF
    do_clr();
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(1'b0);
    check("clr_sync_before", int'(sync), 1);
    CLR = 1'b1;
    #1;
    check("clr_async_sync", int'(sync), 0);
    check("clr_async_valid", int'(data_valid), 0);
    #1;
    CLR = 1'b0;
    for (int i = 0; i < 7; i++) send_frame(1'b1);
    check("clr_no_early_byte", int'(data_valid), 0);
    send_frame(1'b1);
    check("clr_ff_data", int'(data), 8'hFF);
    check("clr_ff_valid", int'(data_valid), 1);
    $display("scenario reset mid-byte done");

`ifdef FRAME_ERR_CNT_EN
    // Start violations saturate the error counter
    do_clr();
    send_frame(1'b0);
    send_bit(1'b0);
    check("cnt_first", int'(err_cnt), 1);
    for (int i = 1; i < 300; i++) begin
      send_frame(1'b0);
      send_bit(1'b0);
    end
    check("cnt_saturated", int'(err_cnt), 8'hFF);
    send_frame(1'b0);
    send_bit(1'b0);
    check("cnt_held", int'(err_cnt), 8'hFF);
    $display("scenario error counter done");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
